// File: rtl/tone_if.sv
// tone_if: mic/enable stimulus toward the classifier and the classified tone/period results back.
interface tone_if #(
    parameter int TONE_W   = 2,
    parameter int PERIOD_W = 18
);
    logic                enable;
    logic                mic;
    logic [TONE_W-1:0]   tone;
    logic                tone_valid;
    logic                tone_change;
    logic [PERIOD_W-1:0] period;
    modport master (output enable, mic, input tone, tone_valid, tone_change, period);
    modport slave (input enable, mic, output tone, tone_valid, tone_change, period);
endinterface

// File: rtl/tone_classifier.sv
// tone_classifier: measures mic square-wave period in clk cycles and classifies it into NUM_TONES tones.
// Optional TONE_GLITCH_FILTER_EN drops mic pulses shorter than GLITCH_CYCLES before edge detection.
module tone_classifier #(
    parameter int                              NUM_TONES     = 3,
    parameter int                              PERIOD_W      = 18,
    parameter logic [NUM_TONES*PERIOD_W-1:0]   TONE_PERIODS  = {18'd200_000, 18'd100_000, 18'd66_667},
    parameter int                              TOL_SHIFT     = 3,
    parameter int                              TIMEOUT       = 250_000,
    parameter int                              CONFIRM       = 3,
    parameter int                              SYNC_STAGES   = 2,
    parameter int                              GLITCH_CYCLES = 16
) (
    input logic   clk,
    input logic   rst_n,
    tone_if.slave bus
);
    localparam int TONE_W = $clog2(NUM_TONES + 1);
    localparam int RUN_W  = $clog2(CONFIRM + 1);

    if (SYNC_STAGES < 2 || CONFIRM < 1 || GLITCH_CYCLES < 1 || TIMEOUT >= 2 ** PERIOD_W) begin : g_bad_params
        $error("tone_classifier: illegal parameter combination");
    end

    logic [SYNC_STAGES-1:0] sync;
    logic                   lvl, lvl_q, rise, armed, change, timeout;
    logic [PERIOD_W-1:0]    count, period;
    logic [PERIOD_W:0]      ref_p, diff;
    logic [TONE_W-1:0]      cls, cand, tone;
    logic [RUN_W-1:0]       run, run_n;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync <= '0;
        else sync <= {sync[SYNC_STAGES-2:0], bus.mic};

`ifdef TONE_GLITCH_FILTER_EN
    localparam int GW = $clog2(GLITCH_CYCLES + 1);
    logic [GW-1:0] glitch_cnt;
    logic          filt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            filt       <= 1'b0;
            glitch_cnt <= '0;
        end else if (sync[SYNC_STAGES-1] == filt) begin
            glitch_cnt <= '0;
        end else if (glitch_cnt == GW'(GLITCH_CYCLES - 1)) begin
            filt       <= sync[SYNC_STAGES-1];
            glitch_cnt <= '0;
        end else begin
            glitch_cnt <= glitch_cnt + 1'b1;
        end
    assign lvl = filt;
`else
    assign lvl = sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            lvl_q <= 1'b0;
            rise  <= 1'b0;
        end else begin
            lvl_q <= lvl;
            rise  <= lvl & ~lvl_q;
        end

    // Iterate from the highest index down so the lowest matching tone wins on overlap.
    always_comb begin
        cls   = '0;
        ref_p = '0;
        diff  = '0;
        for (int i = NUM_TONES - 1; i >= 0; i--) begin
            ref_p = {1'b0, TONE_PERIODS[i*PERIOD_W +: PERIOD_W]};
            diff  = ({1'b0, count} >= ref_p) ? {1'b0, count} - ref_p : ref_p - {1'b0, count};
            if (diff <= (ref_p >> TOL_SHIFT)) cls = TONE_W'(i + 1);
        end
    end

    assign run_n   = (cls != cand) ? RUN_W'(1) : (run == RUN_W'(CONFIRM)) ? run : run + 1'b1;
    assign timeout = armed && count == PERIOD_W'(TIMEOUT);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            count  <= '0;
            armed  <= 1'b0;
            cand   <= '0;
            run    <= '0;
            tone   <= '0;
            period <= '0;
            change <= 1'b0;
        end else if (!bus.enable) begin
            count  <= '0;
            armed  <= 1'b0;
            cand   <= '0;
            run    <= '0;
            tone   <= '0;
            period <= '0;
            change <= 1'b0;
        end else begin
            change <= 1'b0;
            count  <= (count == PERIOD_W'(TIMEOUT)) ? count : count + 1'b1;
            if (rise && armed) begin
                count  <= PERIOD_W'(1);
                period <= count;
                cand   <= cls;
                run    <= run_n;
                if (run_n == RUN_W'(CONFIRM) && cls != tone) begin
                    tone   <= cls;
                    change <= 1'b1;
                end
            end else if (rise) begin
                count <= PERIOD_W'(1);
                armed <= 1'b1;
            end else if (timeout) begin
                armed <= 1'b0;
                cand  <= '0;
                run   <= '0;
                if (tone != '0) begin
                    tone   <= '0;
                    change <= 1'b1;
                end
            end
        end

    assign bus.tone        = tone;
    assign bus.tone_valid  = tone != '0;
    assign bus.tone_change = change;
    assign bus.period      = period;
endmodule

// File: tb/tb_tone_classifier.sv
// tb_tone_classifier: random and directed mic waveforms scored against an event-level tone model.
module tb_tone_classifier;
    localparam int PW      = 12;
    localparam int TIMEOUT = 250;
    localparam int CONFIRM = 3;
    localparam int SYNC    = 2;
`ifdef TONE_GLITCH_FILTER_EN
    localparam int LAT = SYNC + 2 + 16;
`else
    localparam int LAT = SYNC + 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    tone_if #(.TONE_W(2), .PERIOD_W(PW)) bus ();

    tone_classifier #(
        .NUM_TONES(3), .PERIOD_W(PW), .TONE_PERIODS({12'd200, 12'd100, 12'd67}), .TOL_SHIFT(3),
        .TIMEOUT(TIMEOUT), .CONFIRM(CONFIRM), .SYNC_STAGES(SYNC), .GLITCH_CYCLES(16)
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0, errors = 0, cyc = 0, chg_seen = 0;
    int last_rise = 0, tone_m = 0, period_m = 0, chg_m = 0;
    bit armed = 1'b0;
    int hist[$];

    always @(posedge clk) #1 if (bus.tone_change === 1'b1) chg_seen++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".tone"}, 32'(bus.tone), tone_m);
        check({tag, ".valid"}, 32'(bus.tone_valid), 32'(tone_m != 0));
        check({tag, ".period"}, 32'(bus.period), period_m);
        check({tag, ".changes"}, chg_seen, chg_m);
    endtask

    function automatic int tp(input int i);
        return (i == 0) ? 67 : (i == 1) ? 100 : 200;
    endfunction

    function automatic int classify(input int p);
        for (int i = 0; i < 3; i++)
            if (((p > tp(i)) ? p - tp(i) : tp(i) - p) <= tp(i) / 8) return i + 1;
        return 0;
    endfunction

    function automatic bit confirmed();
        if (hist.size() < CONFIRM) return 1'b0;
        for (int i = 1; i < CONFIRM; i++)
            if (hist[hist.size() - 1 - i] != hist[hist.size() - 1]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic expire();
        armed = 1'b0;
        hist.delete();
        if (tone_m != 0) begin
            tone_m = 0;
            chg_m++;
        end
    endtask

    task automatic model_clear();
        armed = 1'b0;
        hist.delete();
        tone_m = 0;
        period_m = 0;
    endtask

    // A pin rise at cycle t: measure against the previous rise unless the gap already timed out.
    task automatic model_rise(input int t);
        if (armed && t - last_rise > TIMEOUT) expire();
        if (armed) begin
            period_m = t - last_rise;
            hist.push_back(classify(period_m));
            if (confirmed() && hist[hist.size() - 1] != tone_m) begin
                tone_m = hist[hist.size() - 1];
                chg_m++;
            end
        end
        armed = 1'b1;
        last_rise = t;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic send_period(input int p);
        int h;
        h = $urandom_range(20, p - 20);
        bus.mic = 1'b1;
        model_rise(cyc);
        for (int k = 1; k <= p; k++) begin
            tick();
            if (k == LAT) check_all("rise");
            if (k == h) bus.mic = 1'b0;
        end
    endtask

    initial begin
        int kind, n, base, p;
        bus.enable = 1'b1;
        bus.mic = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        check_all("reset");
        check("reset.pulse", 32'(bus.tone_change), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        repeat (4) send_period(200);
        check("t1.tone3", 32'(bus.tone), 3);

        for (int b = 0; b < 30; b++) begin
            kind = $urandom_range(0, 6);
            n = $urandom_range(1, 5);
            base = tp($urandom_range(0, 2));
            for (int j = 0; j < n; j++) begin
                case (kind)
                    0, 1, 2: p = base - base / 8 + int'($urandom_range(0, 2 * (base / 8)));
                    3:       p = base + (($urandom_range(0, 1) != 0) ? 1 : -1) * (base / 8 + int'($urandom_range(0, 1)));
                    4:       p = $urandom_range(45, 240);
                    5:       p = TIMEOUT;
                    default: p = $urandom_range(TIMEOUT + 1, TIMEOUT + 40);
                endcase
                send_period(p);
            end
        end

        repeat (4) send_period(200);
        check("stuck.pre", 32'(bus.tone), 3);
        bus.mic = 1'b1;
        model_rise(cyc);
        for (int k = 1; k <= LAT + TIMEOUT + 5; k++) begin
            tick();
            if (k == LAT) check_all("stuck.rise");
            if (k == LAT + TIMEOUT - 1) check("stuck.before", 32'(bus.tone), tone_m);
            if (k == LAT + TIMEOUT) begin
                expire();
                check_all("stuck.timeout");
            end
        end
        bus.mic = 1'b0;
        repeat (30) tick();
        send_period(100);

        repeat (4) send_period(100);
        check("en.tone2", 32'(bus.tone), 2);
        bus.mic = 1'b1;
        model_rise(cyc);
        for (int k = 1; k <= 80; k++) begin
            tick();
            if (k == LAT) check_all("en.rise");
            if (k == 50) bus.mic = 1'b0;
        end
        bus.enable = 1'b0;
        tick();
        model_clear();
        check_all("en.off");
        repeat (5) tick();
        bus.enable = 1'b1;
        tick();
        repeat (4) send_period(67);
        check("en.tone1", 32'(bus.tone), 1);

        bus.mic = 1'b1;
        model_rise(cyc);
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == LAT) check_all("rst.rise");
            if (k == 25) bus.mic = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        check_all("rst.async");
        check("rst.pulse", 32'(bus.tone_change), 0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        repeat (4) send_period(200);
        check("rst.tone3", 32'(bus.tone), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
